// File: rtl/icache_bank_fill_pkg.sv
// rtl/icache_bank_fill_pkg.sv - shared fetch decode helpers and refill FSM state
`ifndef SIZE_PC
`define SIZE_PC 32
`endif

package icache_bank_fill_pkg;

    localparam int BLOCK_INSTS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_DRAIN,
        ST_WRITE
    } fill_state_e;

    // Fetch read select uses these same helpers, so read and write decode stay identical.
    function automatic logic bank_of(input logic [63:0] pc);
        return pc[4];
    endfunction

    function automatic logic [1:0] slot_of(input logic [63:0] pc);
        return pc[3:2];
    endfunction

    function automatic logic [63:0] set_of(input logic [63:0] pc, input int index_bits);
        return (pc >> 5) & ((64'd1 << index_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/icache_bank_fill_if.sv
// rtl/icache_bank_fill_if.sv - miss, memory and bank-write signals of the refill engine
interface icache_bank_fill_if #(
    parameter int SIZE_PC    = `SIZE_PC,
    parameter int INDEX_BITS = 6,
    parameter int INST_W     = 32
);
    localparam int TAG_W = SIZE_PC - 5 - INDEX_BITS;

    logic                  missValid_i;
    logic [SIZE_PC-1:0]    missPC_i;
    logic                  missReady_o;
    logic                  flush_i;
    logic                  memReqValid_o;
    logic [SIZE_PC-1:0]    memReqAddr_o;
    logic                  memReqReady_i;
    logic                  memBeatValid_i;
    logic [INST_W-1:0]     memBeat_i;
    logic                  critValid_o;
    logic [INST_W-1:0]     critInst_o;
    logic                  evenWrEn_o;
    logic                  oddWrEn_o;
    logic [INDEX_BITS-1:0] wrIndex_o;
    logic [TAG_W-1:0]      wrTag_o;
    logic [4*INST_W-1:0]   wrData_o;
    logic                  fillDone_o;

    modport slave (
        input  missValid_i, missPC_i, flush_i, memReqReady_i, memBeatValid_i, memBeat_i,
        output missReady_o, memReqValid_o, memReqAddr_o, critValid_o, critInst_o,
               evenWrEn_o, oddWrEn_o, wrIndex_o, wrTag_o, wrData_o, fillDone_o
    );

    modport master (
        output missValid_i, missPC_i, flush_i, memReqReady_i, memBeatValid_i, memBeat_i,
        input  missReady_o, memReqValid_o, memReqAddr_o, critValid_o, critInst_o,
               evenWrEn_o, oddWrEn_o, wrIndex_o, wrTag_o, wrData_o, fillDone_o
    );
endinterface

// File: rtl/icache_bank_fill_assembler.sv
// rtl/icache_bank_fill_assembler.sv - reorders critical-word-first beats into block order
module fill_block_assembler
    import icache_bank_fill_pkg::*;
#(
    parameter int INST_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [1:0]          start_slot_i,
    input  logic                beat_en_i,
    input  logic                store_i,
    input  logic [INST_W-1:0]   beat_i,
    output logic [1:0]          beat_cnt_o,
    output logic [4*INST_W-1:0] block_o
);

    logic [INST_W-1:0] slot_q [BLOCK_INSTS];
    logic [INST_W-1:0] slot_d [BLOCK_INSTS];
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    always_comb begin
        slot_d = slot_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            ptr_d = start_slot_i;
            cnt_d = 2'd0;
        end else if (beat_en_i) begin
            // Drained beats still advance the count so the fill ends on the 4th beat.
            if (store_i) begin
                slot_d[ptr_q] = beat_i;
            end
            ptr_d = ptr_q + 2'd1;
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BLOCK_INSTS; i++) begin
                slot_q[i] <= '0;
            end
            ptr_q <= 2'd0;
            cnt_q <= 2'd0;
        end else begin
            slot_q <= slot_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        block_o = '0;
        for (int i = 0; i < BLOCK_INSTS; i++) begin
            block_o[i*INST_W +: INST_W] = slot_q[i];
        end
    end

    assign beat_cnt_o = cnt_q;

endmodule

// File: rtl/icache_bank_fill.sv
// rtl/icache_bank_fill.sv - instruction cache refill FSM and memory/bank handshakes
module icache_bank_fill
    import icache_bank_fill_pkg::*;
#(
    parameter int SIZE_PC    = `SIZE_PC,
    parameter int INDEX_BITS = 6,
    parameter int INST_W     = 32
) (
    input logic               clk,
    input logic               reset,
    icache_bank_fill_if.slave bus
);

    fill_state_e         state_q, state_d;
    logic [SIZE_PC-1:0]  pc_q, pc_d;
    logic                crit_valid_q, crit_valid_d;
    logic [INST_W-1:0]   crit_inst_q, crit_inst_d;
    logic                fill_start;
    logic                beat_en;
    logic                beat_store;
    logic [1:0]          beat_cnt;
    logic [4*INST_W-1:0] block;

    fill_block_assembler #(.INST_W(INST_W)) u_assembler (
        .clk          (clk),
        .reset        (reset),
        .start_i      (fill_start),
        .start_slot_i (slot_of(64'(bus.missPC_i))),
        .beat_en_i    (beat_en),
        .store_i      (beat_store),
        .beat_i       (bus.memBeat_i),
        .beat_cnt_o   (beat_cnt),
        .block_o      (block)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        crit_valid_d = 1'b0;
        crit_inst_d  = crit_inst_q;
        fill_start   = 1'b0;
        beat_en      = 1'b0;
        beat_store   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.missValid_i && !bus.flush_i) begin
                    pc_d       = bus.missPC_i;
                    fill_start = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                // Once the request is accepted memory owes four beats, so a flush must drain them.
                if (bus.memReqReady_i) begin
                    state_d = bus.flush_i ? ST_DRAIN : ST_FILL;
                end else if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (bus.memBeatValid_i) begin
                    beat_en    = 1'b1;
                    beat_store = !bus.flush_i;
                    if (beat_cnt == 2'd0 && !bus.flush_i) begin
                        crit_valid_d = 1'b1;
                        crit_inst_d  = bus.memBeat_i;
                    end
                    if (beat_cnt == 2'd3) begin
                        state_d = bus.flush_i ? ST_IDLE : ST_WRITE;
                    end else if (bus.flush_i) begin
                        state_d = ST_DRAIN;
                    end
                end else if (bus.flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.memBeatValid_i) begin
                    beat_en = 1'b1;
                    if (beat_cnt == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            crit_valid_q <= 1'b0;
            crit_inst_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            crit_valid_q <= crit_valid_d;
            crit_inst_q  <= crit_inst_d;
        end
    end

    assign bus.missReady_o   = (state_q == ST_IDLE) && reset;
    assign bus.memReqValid_o = (state_q == ST_REQ);
    assign bus.memReqAddr_o  = {pc_q[SIZE_PC-1:2], 2'b00};
    assign bus.critValid_o   = crit_valid_q;
    assign bus.critInst_o    = crit_inst_q;
    assign bus.evenWrEn_o    = (state_q == ST_WRITE) && !bank_of(64'(pc_q));
    assign bus.oddWrEn_o     = (state_q == ST_WRITE) && bank_of(64'(pc_q));
    assign bus.fillDone_o    = (state_q == ST_WRITE);
    assign bus.wrIndex_o     = INDEX_BITS'(set_of(64'(pc_q), INDEX_BITS));
    assign bus.wrTag_o       = pc_q[SIZE_PC-1:5+INDEX_BITS];
    assign bus.wrData_o      = block;

endmodule

// File: doc/icache_bank_fill.md
# icache_bank_fill

Refill engine for the split even/odd-bank instruction cache. On a fetch miss it requests the 16-byte block containing the miss PC from memory, accepts four 32-bit instruction beats in critical-word-first order, reassembles them into block order, and writes the block into the even or odd bank selected by PC bit 4. It is the write side of the bank/slot decode that fetch uses on read: bank = pc[4], slot = pc[3:2], set = pc[4+INDEX_BITS:5]. It sits between the fetch-1 miss logic and the L2/memory interface.

## Interface
- SIZE_PC, default `SIZE_PC (32): PC width.
- INDEX_BITS, default 6: set-index width per bank; 64 sets per bank.
- INST_W, default 32: instruction width; a block is 4*INST_W.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- missValid_i  in  1  miss request from fetch.
- missPC_i  in  SIZE_PC  miss PC.
- missReady_o  out  1  engine idle; a miss is accepted when missValid_i && missReady_o.
- flush_i  in  1  abort the current fill (redirect); no bank write for an aborted fill.
- memReqValid_o  out  1  memory request valid.
- memReqAddr_o  out  SIZE_PC  {missPC[SIZE_PC-1:2], 2'b00}, the critical word address.
- memReqReady_i  in  1  memory accepts the request.
- memBeatValid_i  in  1  one instruction beat valid; no backpressure.
- memBeat_i  in  INST_W  beat data.
- critValid_o  out  1  one-cycle pulse: the requested instruction is available.
- critInst_o  out  INST_W  requested instruction; valid with critValid_o.
- evenWrEn_o, oddWrEn_o  out  1 each  bank write strobes, mutually exclusive.
- wrIndex_o  out  INDEX_BITS  set index, missPC[4+INDEX_BITS:5].
- wrTag_o  out  SIZE_PC-5-INDEX_BITS  missPC[SIZE_PC-1:5+INDEX_BITS].
- wrData_o  out  4*INST_W  block; slot k occupies bits [k*INST_W +: INST_W].
- fillDone_o  out  1  one-cycle pulse on the bank write cycle.

## Operation
- FSM states: IDLE, REQ, FILL, DRAIN, WRITE.
- IDLE: missReady_o=1. On an accepted miss, latch the PC, set startSlot=pc[3:2] and bank=pc[4], then go to REQ. A flush_i in the same cycle as the miss wins, and the engine stays in IDLE.
- REQ: memReqValid_o=1 and memReqAddr_o stays stable until memReqReady_i. On acceptance go to FILL with beatCnt=0. flush_i in REQ with memReqReady_i=0 returns to IDLE. flush_i with memReqReady_i=1 goes to DRAIN.
- FILL: each memBeatValid_i writes memBeat_i into slot (startSlot+beatCnt) mod 4 (2-bit wrap), then increments beatCnt. Beat 0 also drives critInst_o and pulses critValid_o. On the beat with beatCnt==3, go to WRITE. flush_i in FILL goes to DRAIN and counting continues.
- DRAIN: consume the remaining beats until 4 are counted, with no crit pulse and no write, then go to IDLE. Memory always delivers 4 beats once a request is accepted.
- WRITE: for one cycle, assert evenWrEn_o if bank==0, otherwise oddWrEn_o; pulse fillDone_o; go to IDLE. flush_i in WRITE does not suppress the write, because the block is valid.
- Reset values: state IDLE, beatCnt 0, and every output 0. missReady_o becomes 1 as soon as reset deasserts. memReqAddr_o, wrIndex_o, wrTag_o and wrData_o are 0 while reset is asserted.
- Reset mid-fill: immediate return to IDLE and the partial block is discarded. The memory side is reset by the same signal.

## Timing
- Miss accepted in cycle T gives memReqValid_o=1 in cycle T+1 (registered).
- Beat 0 accepted in cycle B gives critValid_o/critInst_o in cycle B+1 (registered).
- Beat 3 accepted in cycle L gives bank write and fillDone_o in cycle L+1. missReady_o=1 in cycle L+2.
- Minimum fill time: 7 cycles from miss acceptance (1 request cycle, 4 back-to-back beats, 1 write cycle, plus the acceptance cycle). Gaps between beats are allowed.
- Only one fill is outstanding at a time; there are no back-to-back misses without passing through IDLE.

## Structure
- The shared fetch package holds the FSM state enum, the BLOCK_INSTS=4 constant, and the bank/slot/index field-extraction functions. The same functions are used by fetch-side read select, so read and write decode cannot diverge.
- One natural sub-module: `fill_block_assembler`. It holds the 4-slot register array, the wrap-around slot pointer, and the beat counter. The top level holds the FSM and the handshakes.

## Test plan
- Aligned even fill: miss PC 0x0000_1000, request accepted immediately, beats A,B,C,D back-to-back -> memReqAddr_o=0x1000; critInst_o=A one cycle after the first beat; evenWrEn_o=1, wrIndex_o=0, wrData_o={D,C,B,A}; fillDone_o at cycle T+6.
- Critical-word wrap, odd bank: PC 0x0000_103C (slot 3, bank 1, index 1), beats W,X,Y,Z -> critInst_o=W; oddWrEn_o=1, wrIndex_o=1, wrData_o={W,Z,Y,X}.
- Request stall and beat gaps: memReqReady_i low for 3 cycles, 2 idle cycles between beats -> memReqAddr_o stable throughout the stall; correct block written one cycle after the 4th beat.
- Flush in REQ before acceptance -> back to IDLE next cycle, no write. Flush after beat 1 -> beats 2–3 drained, no write strobe, no fillDone_o, missReady_o=1 after the 4th beat.
- Simultaneous missValid_i and flush_i in IDLE -> miss not accepted, memReqValid_o stays 0. flush_i in WRITE -> write still occurs.
- Reset asserted after beat 2 -> all outputs 0 asynchronously. After release, a new fill of PC 0x2010 completes with oddWrEn_o and no data from the aborted fill.
